// File: rtl/anton_neopixel_apb_bridge_pkg.sv
// Shared types and helpers for the neopixel APB bridge.
// FSM encodings, error-count ceiling and channel-index sizing.
package anton_neopixel_apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] ERRCOUNT_MAX = 8'd255;

  // Channel index is always at least one bit wide, even for a single channel.
  function automatic int ch_bits(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

  function automatic int sanitize_channels(input int channels);
    if (channels < 1) return 1;
    if (channels > 16) return 16;
    return channels;
  endfunction

endpackage

// File: rtl/anton_neopixel_apb_bridge_if.sv
// APB slave-side signal bundle for the neopixel bridge.
interface anton_neopixel_apb_bridge_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int APB_ADDR_WIDTH = 22
);
  logic                      apbPselx;
  logic                      apbPenable;
  logic                      apbPwrite;
  logic [APB_ADDR_WIDTH-1:0] apbPaddr;
  logic [DATA_WIDTH-1:0]     apbPwData;
  logic [DATA_WIDTH-1:0]     apbPrData;
  logic                      apbPready;
  logic                      apbPslverr;

  modport master (
    output apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData,
    input  apbPrData, apbPready, apbPslverr
  );

  modport slave (
    input  apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData,
    output apbPrData, apbPready, apbPslverr
  );
endinterface

// File: rtl/anton_neopixel_apb_bridge_wait_timer.sv
// Down-counting request timer: loaded on clear, expires on the TIMEOUT-th enabled cycle.
// TIMEOUT = 0 never expires.
module anton_neopixel_apb_bridge_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LOAD = W'(LOAD_I);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == '0);

endmodule

// File: rtl/anton_neopixel_apb_bridge.sv
// APB slave fronting CHANNELS neopixel bus ports; decodes the channel from upper
// address bits, holds a one-hot strobe until ready/timeout/abort, reports errors on PSLVERR.
module anton_neopixel_apb_bridge
  import anton_neopixel_apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 4,
  parameter int BUS_ADDR_WIDTH = 18,
  parameter int APB_ADDR_WIDTH = 22,
  parameter int TIMEOUT        = 64
) (
  input  logic                           apbPclk_i,
  input  logic                           apbPresern_i,
  anton_neopixel_apb_bridge_if.slave     apb,
  output logic [BUS_ADDR_WIDTH-1:0]      busAddr_o,
  output logic [DATA_WIDTH-1:0]          busDataIn_o,
  output logic [CHANNELS-1:0]            busWrite_o,
  output logic [CHANNELS-1:0]            busRead_o,
  input  logic [CHANNELS*DATA_WIDTH-1:0] busDataOut_i,
  input  logic [CHANNELS-1:0]            busReady_i,
  output logic [7:0]                     errCount_o
);
  localparam int CH_BITS = ch_bits(CHANNELS);
  localparam int CH_N    = sanitize_channels(CHANNELS);

  state_e                    state_q, state_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic [CH_BITS-1:0]        ch_q, ch_d;
  logic                      write_q, write_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic [CHANNELS-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [7:0]                errcnt_q, errcnt_d;

  logic [CH_BITS-1:0]    setup_ch;
  logic [CHANNELS-1:0]   setup_onehot;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  expired;
  logic                  unused_paddr;

  assign setup_ch     = apb.apbPaddr[BUS_ADDR_WIDTH+2 +: CH_BITS];
  assign unused_paddr = ^apb.apbPaddr;

  always_comb begin
    setup_onehot = '0;
    sel_ready    = 1'b0;
    sel_rdata    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      setup_onehot[c] = (setup_ch == CH_BITS'(c));
      if (ch_q == CH_BITS'(c)) begin
        sel_ready = busReady_i[c];
        sel_rdata = busDataOut_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  anton_neopixel_apb_bridge_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (apbPclk_i),
    .rst_ni    (apbPresern_i),
    .clear_i   (state_q != ST_REQ),
    .enable_i  (state_q == ST_REQ),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    ch_d      = ch_q;
    write_d   = write_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    errcnt_d  = errcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (apb.apbPselx && !apb.apbPenable) begin
          ch_d    = setup_ch;
          write_d = apb.apbPwrite;
          if (int'(setup_ch) >= CH_N) begin
            state_d   = ST_DONE;
            prdata_d  = '0;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            // Bus-side address/data only move when a channel is actually strobed.
            state_d = ST_REQ;
            addr_d  = apb.apbPaddr[BUS_ADDR_WIDTH+1:2];
            wdata_d = apb.apbPwData;
            if (apb.apbPwrite) wr_d = setup_onehot;
            else               rd_d = setup_onehot;
          end
        end
      end
      ST_REQ: begin
        if (!apb.apbPselx) begin
          state_d = ST_IDLE;
          wr_d    = '0;
          rd_d    = '0;
        end else if (sel_ready) begin
          state_d   = ST_DONE;
          prdata_d  = write_q ? '0 : sel_rdata;
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
          wr_d      = '0;
          rd_d      = '0;
        end else if (expired) begin
          state_d   = ST_DONE;
          prdata_d  = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          wr_d      = '0;
          rd_d      = '0;
        end
      end
      ST_DONE: begin
        if (!apb.apbPselx || apb.apbPenable) begin
          state_d   = ST_IDLE;
          prdata_d  = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          if (apb.apbPselx && pslverr_q && (errcnt_q != ERRCOUNT_MAX)) begin
            errcnt_d = errcnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge apbPclk_i or negedge apbPresern_i) begin
    if (!apbPresern_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      ch_q      <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      ch_q      <= ch_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign apb.apbPrData  = prdata_q;
  assign apb.apbPready  = pready_q;
  assign apb.apbPslverr = pslverr_q;
  assign busAddr_o      = addr_q;
  assign busDataIn_o    = wdata_q;
  assign busWrite_o     = wr_q;
  assign busRead_o      = rd_q;
  assign errCount_o     = errcnt_q;

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// Self-checking bench: 32-bit, 3-channel bridge with per-channel ready-delay models.
module tb_anton_neopixel_apb_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] busAddr;
  logic [31:0] busDataIn;
  logic [2:0]  busWrite, busRead, busReady;
  logic [95:0] busDataOut;
  logic [7:0]  errCount;

  int          dly[3];
  logic [31:0] rval[3];
  int          scnt[3];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  anton_neopixel_apb_bridge_if #(.DATA_WIDTH(32), .APB_ADDR_WIDTH(22)) apb ();

  anton_neopixel_apb_bridge #(
    .DATA_WIDTH(32), .CHANNELS(3), .BUS_ADDR_WIDTH(18), .APB_ADDR_WIDTH(22), .TIMEOUT(64)
  ) dut (
    .apbPclk_i    (clk),
    .apbPresern_i (rst_n),
    .apb          (apb.slave),
    .busAddr_o    (busAddr),
    .busDataIn_o  (busDataIn),
    .busWrite_o   (busWrite),
    .busRead_o    (busRead),
    .busDataOut_i (busDataOut),
    .busReady_i   (busReady),
    .errCount_o   (errCount)
  );

  // Channel c raises ready once its strobe has been high for dly[c] earlier cycles.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) scnt[c] <= (busWrite[c] | busRead[c]) ? scnt[c] + 1 : 0;
  end

  always_comb begin
    busReady   = '0;
    busDataOut = '0;
    for (int c = 0; c < 3; c++) begin
      busReady[c] = (busWrite[c] | busRead[c]) && (scnt[c] >= dly[c]);
      busDataOut[c*32 +: 32] = rval[c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [21:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input int exp_scyc, input logic [2:0] exp_strb);
    exp_t       e;
    int         n;
    int         scyc;
    logic [2:0] sor;
    bit         done;
    sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat});
    @(negedge clk);
    apb.apbPselx   = 1'b1;
    apb.apbPenable = 1'b0;
    apb.apbPwrite  = wr;
    apb.apbPaddr   = addr;
    apb.apbPwData  = wd;
    @(negedge clk);
    apb.apbPenable = 1'b1;
    n = 0; scyc = 0; sor = '0; done = 1'b0;
    while (!done && n < 200) begin
      if (|busWrite || |busRead) begin
        scyc++;
        sor |= wr ? busWrite : busRead;
      end
      if (apb.apbPready) begin
        e = sb.pop_front();
        chk("prdata",  apb.apbPrData, e.rd);
        chk("pslverr", 32'(apb.apbPslverr), 32'(e.err));
        chk("latency", 32'(n), 32'(e.lat));
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("xfer_done", 32'(done), 32'd1);
    if (!done && sb.size() > 0) e = sb.pop_front();
    apb.apbPselx   = 1'b0;
    apb.apbPenable = 1'b0;
    chk("pready_clr", 32'(apb.apbPready), 32'd0);
    chk("strb_cycles", 32'(scyc), 32'(exp_scyc));
    chk("strb_bits", 32'(sor), 32'(exp_strb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    apb.apbPselx = 1'b0; apb.apbPenable = 1'b0; apb.apbPwrite = 1'b0;
    apb.apbPaddr = '0;   apb.apbPwData = '0;
    for (int c = 0; c < 3; c++) begin dly[c] = 0; rval[c] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_pready",  32'(apb.apbPready), 32'd0);
    chk("rst_prdata",  apb.apbPrData, 32'd0);
    chk("rst_strobes", 32'({busWrite, busRead}), 32'd0);
    chk("rst_errcnt",  32'(errCount), 32'd0);
    chk("rst_busaddr", 32'(busAddr), 32'd0);
    rst_n = 1'b1;

    // Write ch2, busAddr 2, ready immediately
    xfer(1'b1, 22'h200008, 32'hA5, 32'h0, 1'b0, 1, 1, 3'b100);
    chk("wr_busaddr", 32'(busAddr), 32'd2);
    chk("wr_busdata", busDataIn, 32'hA5);
    chk("wr_errcnt",  32'(errCount), 32'd0);

    // Read ch1 with ready delayed 5 cycles
    dly[1] = 5; rval[1] = 32'h3C;
    xfer(1'b0, 22'h100040, 32'h0, 32'h3C, 1'b0, 6, 6, 3'b010);
    chk("rd_busaddr", 32'(busAddr), 32'h10);

    // Channel 3 does not exist
    xfer(1'b0, 22'h300000, 32'h0, 32'h0, 1'b1, 0, 0, 3'b000);
    chk("bad_errcnt", 32'(errCount), 32'd1);

    // Ready stuck low on ch2 -> timeout after 64 strobe cycles
    dly[2] = 1000; rval[2] = 32'h99;
    xfer(1'b0, 22'h200000, 32'h0, 32'h0, 1'b1, 64, 64, 3'b100);
    chk("to_errcnt", 32'(errCount), 32'd2);

    // Abort during the third REQ cycle
    dly[0] = 1000; rval[0] = 32'h11;
    @(negedge clk);
    apb.apbPselx = 1'b1; apb.apbPenable = 1'b0; apb.apbPwrite = 1'b0; apb.apbPaddr = 22'h000004;
    @(negedge clk);
    apb.apbPenable = 1'b1;
    chk("ab_req1", 32'(busRead), 32'b001);
    @(negedge clk);
    @(negedge clk);
    chk("ab_req3", 32'(busRead), 32'b001);
    apb.apbPselx = 1'b0; apb.apbPenable = 1'b0;
    @(negedge clk);
    chk("ab_strobe", 32'(busRead), 32'd0);
    chk("ab_pready", 32'(apb.apbPready), 32'd0);
    chk("ab_errcnt", 32'(errCount), 32'd2);

    // Full 32-bit read data
    dly[1] = 0; rval[1] = 32'hDEADBEEF;
    xfer(1'b0, 22'h100000, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1, 3'b010);

    // Error counter saturation
    for (int i = 0; i < 300; i++) xfer(1'b1, 22'h3000F0, 32'h1, 32'h0, 1'b1, 0, 0, 3'b000);
    chk("sat_errcnt", 32'(errCount), 32'd255);

    // Asynchronous reset while a write is pending
    @(negedge clk);
    apb.apbPselx = 1'b1; apb.apbPenable = 1'b0; apb.apbPwrite = 1'b1;
    apb.apbPaddr = 22'h00007C; apb.apbPwData = 32'h55;
    @(negedge clk);
    apb.apbPenable = 1'b1;
    chk("mr_strobe_pre", 32'(busWrite), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_strobe",  32'({busWrite, busRead}), 32'd0);
    chk("mr_busaddr", 32'(busAddr), 32'd0);
    chk("mr_busdata", busDataIn, 32'd0);
    chk("mr_errcnt",  32'(errCount), 32'd0);
    chk("mr_pready",  32'({apb.apbPready, apb.apbPslverr}), 32'd0);
    apb.apbPselx = 1'b0; apb.apbPenable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    dly[1] = 0;
    xfer(1'b1, 22'h10000C, 32'h77, 32'h0, 1'b0, 1, 1, 3'b010);
    chk("post_busaddr", 32'(busAddr), 32'd3);
    chk("post_busdata", busDataIn, 32'h77);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
